// File: rtl/mina_fetch_unit.sv
`timescale 1ns/1ps
// mina_fetch_unit: decoupled instruction fetch front end for the MINA pipeline.
// Issues pipelined requests to a variable-latency IMEM, buffers returned words
// in a DEPTH-entry queue and hands them to ID with a valid/ready handshake.
// A branch redirect flushes the queue and discards every in-flight response.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   imem_req_valid/ready/addr   fetch request channel (addr word aligned)
//   imem_rsp_valid/data         in-order responses, no backpressure
//   branch_req, branch_ia       redirect from EX (branch_ia[1:0] ignored)
//   id_valid/ready              queue head handshake to ID
//   id_ir, id_ia_plus_4         head instruction and its address + 4
//   occupancy                   queue entries in use
//
// Optional feature macro MINA_FETCH_PERF_EN adds perf_bubble_cnt and
// perf_flush_cnt (saturating 32-bit counters).
module mina_fetch_unit #(
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [31:0] INITIAL_IA      = 32'h0000_0000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    output logic                         imem_req_valid,
    input  logic                         imem_req_ready,
    output logic [31:0]                  imem_req_addr,
    input  logic                         imem_rsp_valid,
    input  logic [31:0]                  imem_rsp_data,
    input  logic                         branch_req,
    input  logic [31:0]                  branch_ia,
    output logic                         id_valid,
    input  logic                         id_ready,
    output logic [31:0]                  id_ir,
    output logic [31:0]                  id_ia_plus_4,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
`ifdef MINA_FETCH_PERF_EN
    ,
    output logic [31:0]                  perf_bubble_cnt,
    output logic [31:0]                  perf_flush_cnt
`endif
);

    localparam int unsigned QAW = $clog2(DEPTH);
    localparam int unsigned OW  = $clog2(DEPTH + 1);
    localparam int unsigned AAW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned SW  = OW + 1;

    logic [31:0]    r_ia;
    logic [31:0]    r_afifo [MAX_OUTSTANDING];
    logic [AAW-1:0] r_af_wr;
    logic [AAW-1:0] r_af_rd;
    logic [CW-1:0]  r_out;
    logic [CW-1:0]  r_discard;
    logic [31:0]    r_q_ir  [DEPTH];
    logic [31:0]    r_q_ia4 [DEPTH];
    logic [QAW-1:0] r_q_wr;
    logic [QAW-1:0] r_q_rd;
    logic [OW-1:0]  r_occ;

    logic        w_credit_ok;
    logic        w_req_fire;
    logic        w_push;
    logic        w_drop;
    logic        w_pop;
    logic [31:0] w_rsp_addr;

    // Address FIFO depth need not be a power of two, so wrap explicitly.
    function automatic logic [AAW-1:0] af_inc(input logic [AAW-1:0] p);
        return (p == AAW'(MAX_OUTSTANDING - 1)) ? '0 : p + AAW'(1);
    endfunction

    // Credit check guarantees every accepted request has a queue slot waiting.
    assign w_credit_ok = (r_out < CW'(MAX_OUTSTANDING)) &&
                         ((SW'(r_occ) + SW'(r_out)) < SW'(DEPTH));
    assign imem_req_valid = rst_n && !branch_req && w_credit_ok;
    assign imem_req_addr  = r_ia;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    // A response is kept only outside a branch cycle and with nothing left to discard.
    assign w_rsp_addr = r_afifo[r_af_rd];
    assign w_push     = imem_rsp_valid && !branch_req && (r_discard == '0);
    assign w_drop     = imem_rsp_valid && !w_push;
    assign w_pop      = id_valid && id_ready && !branch_req;

    assign id_valid     = (r_occ != '0);
    assign id_ir        = r_q_ir[r_q_rd];
    assign id_ia_plus_4 = r_q_ia4[r_q_rd];
    assign occupancy    = r_occ;

    // Fetch address, in-flight tracking and instruction queue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ia      <= INITIAL_IA;
            r_af_wr   <= '0;
            r_af_rd   <= '0;
            r_out     <= '0;
            r_discard <= '0;
            r_q_wr    <= '0;
            r_q_rd    <= '0;
            r_occ     <= '0;
            for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
                r_afifo[i] <= '0;
            end
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_q_ir[i]  <= '0;
                r_q_ia4[i] <= '0;
            end
        end else begin
            if (branch_req) begin
                r_ia <= branch_ia & 32'hFFFF_FFFC;
            end else if (w_req_fire) begin
                r_ia <= r_ia + 32'd4;
            end

            if (w_req_fire) begin
                r_afifo[r_af_wr] <= r_ia;
                r_af_wr          <= af_inc(r_af_wr);
            end
            if (imem_rsp_valid) begin
                r_af_rd <= af_inc(r_af_rd);
            end
            r_out <= r_out + CW'(w_req_fire) - CW'(imem_rsp_valid);

            // Everything still in flight after this cycle belongs to the old path.
            if (branch_req) begin
                r_discard <= r_out - CW'(imem_rsp_valid);
            end else if (w_drop) begin
                r_discard <= r_discard - CW'(1);
            end

            if (branch_req) begin
                r_q_wr <= '0;
                r_q_rd <= '0;
                r_occ  <= '0;
            end else begin
                if (w_push) begin
                    r_q_ir[r_q_wr]  <= imem_rsp_data;
                    r_q_ia4[r_q_wr] <= w_rsp_addr + 32'd4;
                    r_q_wr          <= r_q_wr + QAW'(1);
                end
                if (w_pop) begin
                    r_q_rd <= r_q_rd + QAW'(1);
                end
                r_occ <= r_occ + OW'(w_push) - OW'(w_pop);
            end
        end
    end

`ifdef MINA_FETCH_PERF_EN
    logic [31:0] r_bubble_cnt;
    logic [31:0] r_flush_cnt;

    // Saturating counters: empty-head cycles and dropped responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bubble_cnt <= '0;
            r_flush_cnt  <= '0;
        end else begin
            if (!id_valid && (r_bubble_cnt != 32'hFFFF_FFFF)) begin
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
            end
            if (w_drop && (r_flush_cnt != 32'hFFFF_FFFF)) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign perf_bubble_cnt = r_bubble_cnt;
    assign perf_flush_cnt  = r_flush_cnt;
`endif

endmodule

// File: tb/tb_mina_fetch_unit.sv
`timescale 1ns/1ps
// Testbench for mina_fetch_unit: directed phases, IMEM model returning the
// request address as data, scoreboard of expected {ir, ia_plus_4} pairs.
module tb_mina_fetch_unit;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned MAXO  = 2;
    localparam int unsigned OW    = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] ia4;
    } exp_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] due;
    } pend_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          imem_req_valid;
    logic          imem_req_ready;
    logic [31:0]   imem_req_addr;
    logic          imem_rsp_valid;
    logic [31:0]   imem_rsp_data;
    logic          branch_req;
    logic [31:0]   branch_ia;
    logic          id_valid;
    logic          id_ready;
    logic [31:0]   id_ir;
    logic [31:0]   id_ia_plus_4;
    logic [OW-1:0] occupancy;
`ifdef MINA_FETCH_PERF_EN
    logic [31:0]   perf_bubble_cnt;
    logic [31:0]   perf_flush_cnt;
`endif

    exp_t        exp_q[$];
    pend_t       pend_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int unsigned cyc = 0;
    int unsigned lat = 1;
    bit          rnd_mode = 1'b0;

    always #5 clk = ~clk;

    mina_fetch_unit #(
        .DEPTH(DEPTH),
        .MAX_OUTSTANDING(MAXO),
        .INITIAL_IA(32'h0000_0000)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data),
        .branch_req(branch_req),
        .branch_ia(branch_ia),
        .id_valid(id_valid),
        .id_ready(id_ready),
        .id_ir(id_ir),
        .id_ia_plus_4(id_ia_plus_4),
        .occupancy(occupancy)
`ifdef MINA_FETCH_PERF_EN
        ,
        .perf_bubble_cnt(perf_bubble_cnt),
        .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
        end
    endtask

    task automatic push_stream(input logic [31:0] start, input int n);
        logic [31:0] a;
        a = start;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({a, a + 32'd4});
            a = a + 32'd4;
        end
    endtask

    // Wait for every expected entry to be delivered, then stall ID.
    task automatic drain(input int budget, input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        id_ready = 1'b0;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s: %0d entries undelivered, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic do_branch(input logic [31:0] tgt, input int n, input logic rdy);
        @(posedge clk);
        #1;
        branch_req = 1'b1;
        branch_ia  = tgt;
        exp_q.delete();
        push_stream(tgt & 32'hFFFF_FFFC, n);
        id_ready = rdy;
        @(posedge clk);
        #1;
        branch_req = 1'b0;
    endtask

    // IMEM model: drives ready and in-order responses just after each edge.
    always @(posedge clk) begin
        cyc++;
        #1;
        imem_req_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = pend_q[0].addr;
            void'(pend_q.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    end

    // Record requests that will be accepted at the coming edge.
    always @(negedge clk) begin : rec
        pend_t p;
        if (rst_n && imem_req_valid && imem_req_ready) begin
            p.addr = imem_req_addr;
            p.due  = cyc + (rnd_mode ? $urandom_range(1, 4) : lat);
            pend_q.push_back(p);
        end
    end

    // Monitor: every handshake to ID is compared against the scoreboard.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && id_valid && id_ready && !branch_req) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL deliver: got ir=0x%08h ia_plus_4=0x%08h, expected no delivery",
                         id_ir, id_ia_plus_4);
            end else begin
                e = exp_q.pop_front();
                if (id_ir !== e.ir || id_ia_plus_4 !== e.ia4) begin
                    n_err++;
                    $display("FAIL deliver: got ir=0x%08h ia_plus_4=0x%08h, expected ir=0x%08h ia_plus_4=0x%08h",
                             id_ir, id_ia_plus_4, e.ir, e.ia4);
                end
            end
        end
    end

    initial begin
        int k;
        rst_n          = 1'b0;
        branch_req     = 1'b0;
        branch_ia      = '0;
        id_ready       = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;

        // Reset state
        #12;
        check("reset_req_valid", 32'(imem_req_valid), 32'd0);
        check("reset_id_valid", 32'(id_valid), 32'd0);
        check("reset_occupancy", 32'(occupancy), 32'd0);
        check("reset_req_addr", imem_req_addr, 32'h0);

        // Release and first-delivery latency
        @(posedge clk);
        #1;
        push_stream(32'h0, 8);
        rst_n = 1'b1;
        @(negedge clk);
        check("first_req_valid", 32'(imem_req_valid), 32'd1);
        check("first_req_addr", imem_req_addr, 32'h0);
        @(negedge clk);
        check("id_valid_cycle1", 32'(id_valid), 32'd0);
        @(negedge clk);
        check("id_valid_cycle2", 32'(id_valid), 32'd1);
        check("first_ir", id_ir, 32'h0);
        check("first_ia_plus_4", id_ia_plus_4, 32'h4);
        drain(50, "stream0");

        // ID stall: queue fills, fetch stops, head holds
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("stall_occupancy", 32'(occupancy), 32'd4);
        check("stall_req_valid", 32'(imem_req_valid), 32'd0);
        check("stall_ir", id_ir, 32'h20);
        check("stall_ia_plus_4", id_ia_plus_4, 32'h24);
        repeat (3) @(negedge clk);
        check("stall_ir_hold", id_ir, 32'h20);
        check("stall_ia4_hold", id_ia_plus_4, 32'h24);
        @(posedge clk);
        #1;
        push_stream(32'h20, 8);
        id_ready = 1'b1;
        drain(50, "resume");

        // Branch with two requests outstanding, latency 3
        repeat (8) @(posedge clk);
        lat = 3;
        do_branch(32'h40, 0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        branch_req = 1'b1;
        branch_ia  = 32'h100;
        exp_q.delete();
        push_stream(32'h100, 4);
        @(posedge clk);
        #1;
        branch_req = 1'b0;
        @(negedge clk);
        check("flush_occupancy", 32'(occupancy), 32'd0);
        drain(60, "branch_100");
`ifdef MINA_FETCH_PERF_EN
        check("perf_flush_cnt", perf_flush_cnt, 32'd2);
`endif
        lat = 1;

        // Branch coinciding with a response
        do_branch(32'h180, 0, 1'b0);
        k = 0;
        do begin
            @(posedge clk);
            #2;
            k++;
        end while (!imem_rsp_valid && k < 20);
        check("rsp_before_branch", 32'(imem_rsp_valid), 32'd1);
        branch_req = 1'b1;
        branch_ia  = 32'h200;
        exp_q.delete();
        push_stream(32'h200, 4);
        @(negedge clk);
        check("branch_cycle_req_valid", 32'(imem_req_valid), 32'd0);
        @(posedge clk);
        #1;
        branch_req = 1'b0;
        @(negedge clk);
        check("after_branch_id_valid", 32'(id_valid), 32'd0);
        check("after_branch_req_valid", 32'(imem_req_valid), 32'd1);
        check("after_branch_req_addr", imem_req_addr, 32'h200);
        @(posedge clk);
        #1;
        id_ready = 1'b1;
        drain(50, "branch_200");

        // Random IMEM ready and latency over 1000 instructions
        rnd_mode = 1'b1;
        do_branch(32'h0, 1000, 1'b1);
        drain(20000, "random_1000");
        rnd_mode = 1'b0;

        // Address wrap; low target bits ignored
        do_branch(32'hFFFF_FFFA, 3, 1'b1);
        drain(50, "wrap");

        // Asynchronous reset mid-burst
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("pre_reset_id_valid", 32'(id_valid), 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        pend_q.delete();
        exp_q.delete();
        #1;
        check("async_req_valid", 32'(imem_req_valid), 32'd0);
        check("async_id_valid", 32'(id_valid), 32'd0);
        check("async_occupancy", 32'(occupancy), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        push_stream(32'h0, 4);
        id_ready = 1'b1;
        rst_n    = 1'b1;
        drain(50, "post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
